block_ctrl: RTL and testbench

- Drives the moving-block interface of the playfield bitmap: cur_blk_row, cur_blk_col, cur_blk_data and falling_update.
- Consumes the bitmap's returned status: cur_blk_act, left_en, right_en, up_en and game_over.
- Spawns pieces, applies gravity ticks and player moves/rotation, and locks the piece when the bitmap reports it has landed.
- Sits between the debounced button front-end and the bitmap.

---
 rtl/tetris_pkg.sv | 60 ++++++
 rtl/piece_rng.sv | 29 ++
 rtl/block_ctrl.sv | 171 +++++++++++++++++
 tb/tb_block_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-block controller: piece shapes,
// controller states, LFSR constants and small combinational helpers.
package tetris_pkg;

    localparam logic [15:0] SHAPE_I = 16'h000F;
    localparam logic [15:0] SHAPE_O = 16'h0033;
    localparam logic [15:0] SHAPE_T = 16'h0027;
    localparam logic [15:0] SHAPE_S = 16'h0036;
    localparam logic [15:0] SHAPE_Z = 16'h0063;
    localparam logic [15:0] SHAPE_L = 16'h0017;
    localparam logic [15:0] SHAPE_J = 16'h0047;
    localparam int          NUM_SHAPES = 7;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0;
    // the tapped stages are bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        SPAWN,
        SETTLE,
        ACTIVE,
        LOCK,
        OVER
    } state_e;

    // Shape bitmap for a piece index; index 7 never occurs.
    function automatic logic [15:0] shape_of(input logic [2:0] idx);
        logic [15:0] s;
        case (idx)
            3'd0:    s = SHAPE_I;
            3'd1:    s = SHAPE_O;
            3'd2:    s = SHAPE_T;
            3'd3:    s = SHAPE_S;
            3'd4:    s = SHAPE_Z;
            3'd5:    s = SHAPE_L;
            3'd6:    s = SHAPE_J;
            default: s = SHAPE_I;
        endcase
        return s;
    endfunction

    // Three low LFSR bits to a piece index, folding the unused code 7 onto 0.
    function automatic logic [2:0] lfsr_index(input logic [2:0] low_bits);
        return (low_bits == 3'd7) ? 3'd0 : low_bits;
    endfunction

    // Quarter turn of the 4x4 block: new[4r+c] = old[4c+3-r].
    function automatic logic [15:0] rotate_blk(input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[4*i+j] = b[4*j+3-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piece_rng.sv
// Free-running 16-bit LFSR that supplies the next piece index every cycle.
module piece_rng
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    output logic [2:0] piece_idx_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Feedback bit from the tapped stages enters at the top.
    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    // Shift every cycle; reset reloads the seed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign piece_idx_o = lfsr_index(lfsr_q[2:0]);

endmodule

// File: rtl/block_ctrl.sv
// Moving-block controller: spawns pieces, applies gravity and player moves,
// and hands a landed piece back to the playfield bitmap for merging.
module block_ctrl
    import tetris_pkg::*;
#(
    parameter int AREA_ROW   = 32,
    parameter int AREA_COL   = 16,
    parameter int ROW_ADDR_W = 5,
    parameter int COL_ADDR_W = 4,
    parameter int SPEED_FREQ = 50_000_000,
    parameter int SPAWN_COL  = 6,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  cur_blk_act,
    input  logic                  left_en,
    input  logic                  right_en,
    input  logic                  up_en,
    input  logic                  game_over,
    output logic [ROW_ADDR_W-1:0] cur_blk_row,
    output logic [COL_ADDR_W-1:0] cur_blk_col,
    output logic [15:0]           cur_blk_data,
    output logic [15:0]           next_blk_data,
    output logic                  falling_update
);

    localparam int TICK_W   = (SPEED_FREQ > 1) ? $clog2(SPEED_FREQ) : 1;
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [ROW_ADDR_W-1:0] ROW_LAST  = ROW_ADDR_W'(AREA_ROW - 1);
    localparam logic [COL_ADDR_W-1:0] COL_SPAWN = COL_ADDR_W'(SPAWN_COL);
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(SPEED_FREQ - 1);
    localparam logic [SETTLE_W-1:0]   SET_LAST  = SETTLE_W'(SETTLE_CYC - 1);

    // The playfield must fit in the address space of the block position.
    if ((AREA_COL > (1 << COL_ADDR_W)) || (AREA_ROW > (1 << ROW_ADDR_W))) begin : g_area_chk
        $error("block_ctrl: playfield does not fit the row/column address width");
    end

    state_e                 state_q;
    logic [ROW_ADDR_W-1:0]  row_q;
    logic [COL_ADDR_W-1:0]  col_q;
    logic [15:0]            data_q;
    logic [2:0]             next_idx_q;
    logic                   fall_q;
    logic [SETTLE_W-1:0]    settle_q;
    logic [TICK_W-1:0]      tick_cnt_q;
    logic [TICK_W-1:0]      tick_cnt_d;
    logic                   tick_pend_q;
    logic                   tick_pend_d;
    logic                   tick_wrap;
    logic                   fall_go;
    logic                   tick_clr;
    logic [2:0]             rng_idx;

    piece_rng u_rng (
        .clk         (clk),
        .rstn        (rstn),
        .piece_idx_o (rng_idx)
    );

    // Gravity timebase and the pending-tick flag; a wrap in the same cycle
    // as a consume leaves a fresh tick pending.
    always_comb begin
        fall_go   = (state_q == ACTIVE) && !game_over && cur_blk_act
                    && (tick_pend_q || btn_down);
        tick_clr  = (state_q == SPAWN) || fall_go;
        tick_wrap = (state_q != OVER) && (tick_cnt_q == TICK_LAST);

        tick_cnt_d = tick_cnt_q;
        if (state_q != OVER) begin
            tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
        end

        tick_pend_d = tick_pend_q;
        if (tick_clr) begin
            tick_pend_d = 1'b0;
        end
        if (tick_wrap) begin
            tick_pend_d = 1'b1;
        end
    end

    // Tick counter and pending flag registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    // Block FSM with registered position, shape, preview and fall pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= SPAWN;
            row_q      <= '0;
            col_q      <= COL_SPAWN;
            data_q     <= '0;
            next_idx_q <= lfsr_index(LFSR_SEED[2:0]);
            fall_q     <= 1'b0;
            settle_q   <= '0;
        end else begin
            fall_q <= 1'b0;
            case (state_q)
                SPAWN: begin
                    if (game_over) begin
                        state_q <= OVER;
                    end else begin
                        data_q     <= shape_of(next_idx_q);
                        row_q      <= '0;
                        col_q      <= COL_SPAWN;
                        next_idx_q <= rng_idx;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        settle_q <= '0;
                        state_q  <= ACTIVE;
                    end else begin
                        settle_q <= settle_q + SETTLE_W'(1);
                    end
                end
                ACTIVE: begin
                    if (game_over) begin
                        state_q <= OVER;
                    end else if (!cur_blk_act) begin
                        state_q <= LOCK;
                    end else if (fall_go) begin
                        row_q   <= (row_q == ROW_LAST) ? row_q : row_q + ROW_ADDR_W'(1);
                        fall_q  <= 1'b1;
                        state_q <= SETTLE;
                    end else if (btn_up && up_en) begin
                        data_q  <= rotate_blk(data_q);
                        state_q <= SETTLE;
                    end else if (btn_left && left_en) begin
                        col_q   <= col_q - COL_ADDR_W'(1);
                        state_q <= SETTLE;
                    end else if (btn_right && right_en) begin
                        col_q   <= col_q + COL_ADDR_W'(1);
                        state_q <= SETTLE;
                    end
                end
                LOCK: begin
                    state_q <= SPAWN;
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= SPAWN;
                end
            endcase
        end
    end

    assign cur_blk_row    = row_q;
    assign cur_blk_col    = col_q;
    assign cur_blk_data   = data_q;
    assign next_blk_data  = shape_of(next_idx_q);
    assign falling_update = fall_q;

endmodule

// File: tb/tb_block_ctrl.sv
// Bench for block_ctrl: directed table, multi-cycle sequences and random
// stimulus, all compared against a behavioural model of the controller.
module tb_block_ctrl;

    localparam int SF       = 8;
    localparam int SETTLE_N = 2;
    localparam int LAST_ROW = 31;

    localparam int M_SPAWN  = 0;
    localparam int M_SETTLE = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_LOCK   = 3;
    localparam int M_OVER   = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
    logic act = 1'b1, len = 1'b1, ren = 1'b1, uen = 1'b1, go = 1'b0;
    logic [4:0]  row;
    logic [3:0]  col;
    logic [15:0] data;
    logic [15:0] nxt;
    logic        fu;

    int checks = 0;
    int failures = 0;

    // Model state
    int          m_row, m_col, m_next, m_tcnt, m_mode, m_hold;
    logic [15:0] m_data, m_lfsr;
    bit          m_fu, m_pend;

    always #5 clk = ~clk;

    block_ctrl #(
        .AREA_ROW(32), .AREA_COL(16), .ROW_ADDR_W(5), .COL_ADDR_W(4),
        .SPEED_FREQ(SF), .SPAWN_COL(6), .SETTLE_CYC(SETTLE_N)
    ) dut (
        .clk(clk), .rstn(rstn),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
        .cur_blk_act(act), .left_en(len), .right_en(ren), .up_en(uen),
        .game_over(go),
        .cur_blk_row(row), .cur_blk_col(col), .cur_blk_data(data),
        .next_blk_data(nxt), .falling_update(fu)
    );

    function automatic logic [15:0] shape(input int i);
        logic [15:0] tbl [7];
        tbl = '{16'h000F, 16'h0033, 16'h0027, 16'h0036, 16'h0063, 16'h0017, 16'h0047};
        return tbl[i];
    endfunction

    // Picture the block as a 4x4 grid and turn it a quarter.
    function automatic logic [15:0] rot(input logic [15:0] b);
        bit g [4][4];
        logic [15:0] n;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) g[r][c] = b[4*r+c];
        n = '0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) n[4*r+c] = g[c][3-r];
        return n;
    endfunction

    function automatic int piece_of(input logic [15:0] l);
        int v;
        v = int'(l) % 8;
        return (v == 7) ? 0 : v;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        bit fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return (l >> 1) | (16'(fb) << 15);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  idx_now;
        bit  running, wrap, pend_old;
        if (!rstn) begin
            m_row = 0; m_col = 6; m_data = '0; m_fu = 0;
            m_lfsr = 16'hACE1; m_next = piece_of(16'hACE1);
            m_tcnt = 0; m_pend = 0; m_mode = M_SPAWN; m_hold = 0;
            return;
        end
        idx_now  = piece_of(m_lfsr);
        running  = (m_mode != M_OVER);
        wrap     = running && (m_tcnt == SF - 1);
        pend_old = m_pend;
        m_fu     = 0;
        case (m_mode)
            M_SPAWN: begin
                m_pend = 0;
                if (go) m_mode = M_OVER;
                else begin
                    m_data = shape(m_next); m_row = 0; m_col = 6; m_next = idx_now;
                    m_mode = M_SETTLE; m_hold = SETTLE_N;
                end
            end
            M_SETTLE: begin
                m_hold--;
                if (m_hold == 0) m_mode = M_ACTIVE;
            end
            M_ACTIVE: begin
                if (go) m_mode = M_OVER;
                else if (!act) m_mode = M_LOCK;
                else if (pend_old || bd) begin
                    m_row = (m_row < LAST_ROW) ? m_row + 1 : LAST_ROW;
                    m_fu = 1; m_pend = 0; m_mode = M_SETTLE; m_hold = SETTLE_N;
                end else if (bu && uen) begin
                    m_data = rot(m_data); m_mode = M_SETTLE; m_hold = SETTLE_N;
                end else if (bl && len) begin
                    m_col = (m_col + 15) % 16; m_mode = M_SETTLE; m_hold = SETTLE_N;
                end else if (br && ren) begin
                    m_col = (m_col + 1) % 16; m_mode = M_SETTLE; m_hold = SETTLE_N;
                end
            end
            M_LOCK: m_mode = M_SPAWN;
            default: ;
        endcase
        if (wrap) m_pend = 1;
        if (running) m_tcnt = wrap ? 0 : m_tcnt + 1;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // One clock: update model at the edge, compare just after, drop pulses.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle_model", {row, col, data, nxt, fu},
            {5'(m_row), 4'(m_col), m_data, shape(m_next), m_fu});
        bl = 0; br = 0; bu = 0; bd = 0;
    endtask

    task automatic wait_ready(input string name, input bit need_edge);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_ACTIVE && !m_pend && (!need_edge || m_tcnt == SF - 1)) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(name, ok, 1);
    endtask

    task automatic respawn();
        logic [15:0] exp_d;
        wait_ready("lock_wait", 0);
        act = 0;
        step();
        act = 1;
        exp_d = shape(m_next);
        step();
        step();
        chk("spawn_data", data, exp_d);
        chk("spawn_pos", {row, col}, {5'd0, 4'd6});
    endtask

    typedef struct {
        string name;
        bit l, r, u, d, le, re, ue;
        int dcol, drow;
        bit rt, f;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          pulses, seen;
        int          fall_row [2];
        int          pre_row, pre_col, bad;
        logic [15:0] pre_data;
        logic [4:0]  fr_row;
        logic [3:0]  fr_col;
        logic [15:0] fr_data;
        int          fl [4];

        vecs[0]  = '{"left",        1,0,0,0, 1,1,1, -1,0, 0,0};
        vecs[1]  = '{"left_blk",    1,0,0,0, 0,1,1,  0,0, 0,0};
        vecs[2]  = '{"right",       0,1,0,0, 1,1,1,  1,0, 0,0};
        vecs[3]  = '{"right_blk",   0,1,0,0, 1,0,1,  0,0, 0,0};
        vecs[4]  = '{"rot",         0,0,1,0, 1,1,1,  0,0, 1,0};
        vecs[5]  = '{"rot_blk",     0,0,1,0, 1,1,0,  0,0, 0,0};
        vecs[6]  = '{"down",        0,0,0,1, 1,1,1,  0,1, 0,1};
        vecs[7]  = '{"down_left",   1,0,0,1, 1,1,1,  0,1, 0,1};
        vecs[8]  = '{"left_right",  1,1,0,0, 1,1,1, -1,0, 0,0};
        vecs[9]  = '{"up_left",     1,0,1,0, 1,1,1,  0,0, 1,0};
        vecs[10] = '{"idle",        0,0,0,0, 1,1,1,  0,0, 0,0};
        vecs[11] = '{"right_upblk", 0,1,1,0, 1,1,0,  1,0, 0,0};

        // Reset values
        rstn = 0;
        step(); step(); step();
        chk("rst_pos", {row, col}, {5'd0, 4'd6});
        chk("rst_data", data, 16'h0000);
        chk("rst_fu", fu, 1'b0);
        chk("rst_next", nxt, 16'h0033);

        // First spawn loads the O piece
        rstn = 1;
        step();
        chk("spawn_O", data, 16'h0033);
        chk("spawn_O_pos", {row, col}, {5'd0, 4'd6});

        // Gravity: pulses step the row 0 -> 1 -> 2
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            step();
            if (fu) begin fall_row[seen] = int'(row); seen++; end
        end
        chk("fall_seen", seen, 2);
        chk("fall_row1", fall_row[0], 1);
        chk("fall_row2", fall_row[1], 2);
        pulses = 0;
        for (int i = 0; i < 4 * SF; i++) begin step(); pulses += int'(fu); end
        chk("fall_rate", pulses, 4);

        // Tick landing during SETTLE is serviced on ACTIVE entry
        wait_ready("tick_wait", 1);
        pre_row = m_row;
        bd = 1;
        for (int i = 0; i < 4; i++) begin step(); fl[i] = int'(fu); end
        chk("settle_tick_fu", {fl[0], fl[1], fl[2], fl[3]}, {32'd1, 32'd0, 32'd0, 32'd1});
        chk("settle_tick_row", row, 5'((pre_row + 2 > LAST_ROW) ? LAST_ROW : pre_row + 2));

        // Cycle pieces until a T is in play, then rotate it
        for (int k = 0; k < 80 && m_data != 16'h0027; k++) respawn();
        chk("find_T", data, 16'h0027);
        wait_ready("rot_wait0", 0);
        bu = 1; uen = 0;
        step();
        uen = 1;
        chk("rot_en0", data, 16'h0027);
        wait_ready("rot_wait1", 0);
        bu = 1;
        step();
        chk("rot_T", data, 16'h1310);

        // Left moves from the spawn column
        respawn();
        wait_ready("left_wait0", 0);
        chk("left_start", col, 4'd6);
        bl = 1;
        step();
        chk("left_once", col, 4'd5);
        bl = 1;
        step(); step(); step();
        chk("left_drop_settle", col, 4'd5);
        wait_ready("left_wait1", 0);
        bl = 1; len = 0;
        step();
        len = 1;
        chk("left_en0", col, 4'd5);

        // Table of single ACTIVE-cycle actions
        for (int v = 0; v < 12; v++) begin
            wait_ready("vec_wait", 0);
            pre_row = m_row; pre_col = m_col; pre_data = m_data;
            bl = vecs[v].l; br = vecs[v].r; bu = vecs[v].u; bd = vecs[v].d;
            len = vecs[v].le; ren = vecs[v].re; uen = vecs[v].ue;
            step();
            len = 1; ren = 1; uen = 1;
            chk({vecs[v].name, "_col"}, col, 4'((pre_col + vecs[v].dcol + 16) % 16));
            chk({vecs[v].name, "_row"}, row,
                5'((pre_row + vecs[v].drow > LAST_ROW) ? LAST_ROW : pre_row + vecs[v].drow));
            chk({vecs[v].name, "_data"}, data, vecs[v].rt ? rot(pre_data) : pre_data);
            chk({vecs[v].name, "_fu"}, fu, vecs[v].f);
        end

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            act = ($urandom_range(0, 39) != 0);
            bl  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 5) == 0);
            bu  = ($urandom_range(0, 5) == 0);
            bd  = ($urandom_range(0, 7) == 0);
            len = ($urandom_range(0, 3) != 0);
            ren = ($urandom_range(0, 3) != 0);
            uen = ($urandom_range(0, 3) != 0);
            step();
        end
        act = 1; len = 1; ren = 1; uen = 1;

        // Game over: frozen outputs, no falls, buttons ignored
        go = 1;
        for (int i = 0; i < 20 && m_mode != M_OVER; i++) step();
        chk("over_enter", m_mode, M_OVER);
        fr_row = row; fr_col = col; fr_data = data;
        chk("over_model_pos", {fr_row, fr_col, fr_data}, {5'(m_row), 4'(m_col), m_data});
        pulses = 0; bad = 0;
        for (int i = 0; i < 100 * SF; i++) begin
            act = $urandom_range(0, 1); go = $urandom_range(0, 1);
            bl = $urandom_range(0, 1); br = $urandom_range(0, 1);
            bu = $urandom_range(0, 1); bd = $urandom_range(0, 1);
            step();
            pulses += int'(fu);
            if ({row, col, data} !== {fr_row, fr_col, fr_data}) bad++;
        end
        chk("over_fu", pulses, 0);
        chk("over_frozen", bad, 0);

        // Reset leaves OVER
        rstn = 0; go = 0; act = 1;
        step();
        chk("rst2_pos", {row, col}, {5'd0, 4'd6});
        chk("rst2_data", {data, fu}, {16'h0000, 1'b0});
        chk("rst2_next", nxt, 16'h0033);
        rstn = 1;
        step();
        chk("rst2_spawn", data, 16'h0033);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
